fetch_sequencer: RTL and testbench

- Multi-cycle sequencer that drives the single-cycle RV32 core datapath from a handshaked instruction memory.
- Owns PC state; fetches one word per instruction and holds it stable as cmd for the datapath.
- Issues a one-cycle commit strobe that gates register writeback and the PC update.
- Halts on ebreak or a misaligned next PC.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_watchdog.sv | 45 ++++
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch sequencer:
//   - fetch_state_e : sequencer state encoding (FETCH, WAIT, EXEC, HALT)
//   - INSN_NOP / INSN_EBREAK : instruction words the sequencer recognises
//   - DEFAULT_RESET_PC : boot address
//   - wdog_cnt_w() : watchdog counter width, never narrower than 8 bits
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSN_NOP         = 32'h0000_0013;
  localparam logic [31:0] INSN_EBREAK      = 32'h0010_0073;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  function automatic int wdog_cnt_w(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// -----------------------------------------------------------------------------
// fetch_watchdog
// Counts consecutive cycles spent waiting for an instruction-memory response
// and flags a timeout on the last permitted WAIT cycle.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   in_wait  in   sequencer is in WAIT this cycle
//   timeout  out  this WAIT cycle is the WDOG_CYCLES-th one
//
// Parameters:
//   WDOG_CYCLES  number of WAIT cycles allowed before timeout
// -----------------------------------------------------------------------------
module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter int WDOG_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wait,
  output logic timeout
);

  localparam int CW = wdog_cnt_w(WDOG_CYCLES);

  logic [CW-1:0] cnt;

  // Held at zero outside WAIT, so every WAIT entry starts counting from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!in_wait) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the number of WAIT cycles already completed, so cnt equal to
  // WDOG_CYCLES-1 marks the final permitted cycle.
  assign timeout = in_wait && (cnt == CW'(WDOG_CYCLES - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Multi-cycle sequencer that drives a single-cycle RV32 datapath from a
// handshaked instruction memory. It owns the PC, fetches one word per
// instruction, holds it as cmd and emits a one-cycle commit strobe that
// gates register writeback and the PC update. It halts on ebreak or on a
// misaligned next PC.
//
// Optional feature: define FETCH_WDOG_EN to bound the WAIT state with a
// response watchdog (WDOG_CYCLES cycles); a timeout sets fetch_err and halts.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-low reset
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts request
//   imem_addr       out  fetch address (equals pc)
//   imem_rsp_valid  in   read data valid
//   imem_rsp_data   in   instruction word
//   next_pc         in   PC computed by the datapath for the current cmd
//   cmd             out  held instruction word
//   pc              out  PC of cmd
//   commit          out  one-cycle strobe, high only in EXEC when retiring
//   halted          out  sticky halt indicator
//   fetch_err       out  sticky error (misalign, or watchdog when enabled)
//   instret         out  count of committed instructions
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
  parameter int              WDOG_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic [XLEN-1:0] next_pc,
  output logic [31:0]     cmd,
  output logic [XLEN-1:0] pc,
  output logic            commit,
  output logic            halted,
  output logic            fetch_err,
  output logic [63:0]     instret
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         started_q;
  logic         wdog_timeout;
  logic         is_ebreak;
  logic         misaligned;
  logic         err_event;

`ifdef FETCH_WDOG_EN
  fetch_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .in_wait (state_q == WAIT),
    .timeout (wdog_timeout)
  );
`else
  // Without the watchdog a response is awaited indefinitely.
  assign wdog_timeout = 1'b0;
`endif

  assign imem_addr  = pc;
  assign is_ebreak  = (cmd == INSN_EBREAK);
  assign misaligned = (next_pc[1:0] != 2'b00);

  // Next state and state-decoded outputs.
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    commit         = 1'b0;
    err_event      = 1'b0;
    unique case (state_q)
      FETCH: begin
        // started_q keeps the request low until the first edge after reset.
        imem_req_valid = started_q;
        if (started_q && imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response in the timeout cycle takes priority over the timeout.
        if (imem_rsp_valid) begin
          state_d = EXEC;
        end else if (wdog_timeout) begin
          state_d   = HALT;
          err_event = 1'b1;
        end
      end
      EXEC: begin
        if (is_ebreak) begin
          state_d = HALT;
        end else if (misaligned) begin
          state_d   = HALT;
          err_event = 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      started_q <= 1'b0;
      halted    <= 1'b0;
      fetch_err <= 1'b0;
      instret   <= 64'd0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      if (state_d == HALT) begin
        halted <= 1'b1;
      end
      if (err_event) begin
        fetch_err <= 1'b1;
      end
      if (commit) begin
        instret <= instret + 64'd1;
      end
    end
  end

  // cmd and pc only move on response capture and commit, so both stay
  // stable from WAIT exit through the following EXEC and freeze in HALT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc  <= RESET_PC;
      cmd <= INSN_NOP;
    end else begin
      if (state_q == WAIT && imem_rsp_valid) begin
        cmd <= imem_rsp_data;
      end
      if (commit) begin
        pc <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Randomized bench for fetch_sequencer. The bench plays both the instruction
// memory and the datapath: each program is a list of instruction words and
// the next PC for each of them, and a transaction-level model predicts the
// fetch addresses, commit strobes, halt/error flags and retired count.
// Define FETCH_WDOG_EN to also exercise the response watchdog.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int          XLEN = 32;
  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam int          WDOG = 10;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] next_pc;
  logic [31:0] cmd;
  logic [31:0] pc;
  logic        commit;
  logic        halted;
  logic        fetch_err;
  logic [63:0] instret;

  int n_vec = 0;
  int n_err = 0;

  fetch_sequencer #(
    .XLEN        (XLEN),
    .RESET_PC    (RPC),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .next_pc        (next_pc),
    .cmd            (cmd),
    .pc             (pc),
    .commit         (commit),
    .halted         (halted),
    .fetch_err      (fetch_err),
    .instret        (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    next_pc        = RPC;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc",        pc,             RPC);
    chk("rst_cmd",       cmd,            INSN_NOP);
    chk("rst_commit",    commit,         0);
    chk("rst_halted",    halted,         0);
    chk("rst_fetch_err", fetch_err,      0);
    chk("rst_instret",   instret,        0);
    chk("rst_req_valid", imem_req_valid, 0);
    rst = 1'b1;
    #1;
    chk("req_after_release", imem_req_valid, 0);
  endtask

  // Runs one program of n instructions from reset. ebreak_at / misalign_at
  // give the index of the instruction that is an ebreak / has a misaligned
  // successor (-1 for none). branch_mode: 0 sequential, 1 random branches,
  // 2 first instruction branches to 0x80000100.
  task automatic run_prog(input int n, input int ebreak_at, input int misalign_at,
                          input int rdy_pct, input int max_dly, input int stall0,
                          input int branch_mode);
    logic [31:0] wd[$];
    logic [31:0] pl[$];
    logic [31:0] cur;
    logic [31:0] nxt;
    logic [31:0] r;
    logic [31:0] a;
    logic [63:0] ir;
    logic [1:0]  bits;
    bit          hlt;
    bit          err;
    bit          done;
    bit          rsp_now;
    bit          exp_req;
    bit          exp_commit;
    int          phase;   // 0 request pending, 1 awaiting response, 2 executing
    int          dly;
    int          stall;
    int          cyc;
    int          k;
    int          budget;

    cur = RPC;
    for (int i = 0; i < n; i++) begin
      r = $urandom();
      wd.push_back((i == ebreak_at) ? INSN_EBREAK : {r[31:7], 7'h13});
      r = $urandom();
      nxt = cur + 32'd4;
      if (branch_mode == 1 && r[5:4] == 2'b00) nxt = {RPC[31:16], r[15:2], 2'b00};
      if (branch_mode == 2 && i == 0) nxt = 32'h8000_0100;
      if (i == misalign_at) begin
        bits = (branch_mode == 0 || r[1:0] == 2'b00) ? 2'b10 : r[1:0];
        nxt  = cur + {30'd0, bits};
      end
      pl.push_back(nxt);
      cur = nxt;
    end

    do_reset();
    a = RPC; ir = 64'd0; hlt = 0; err = 0; done = 0;
    phase = 0; dly = 0; stall = stall0; cyc = 0; k = 0;
    budget = 200 * n + 100;

    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      rsp_now        = (phase == 1 && dly == 0);
      // Stray response strobes outside WAIT must be ignored.
      imem_rsp_valid = rsp_now || (phase != 1 && $urandom_range(3) == 0);
      imem_rsp_data  = rsp_now ? wd[k] : $urandom();
      imem_req_ready = (stall > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      next_pc        = pl[k];
      #1;
      exp_req    = (phase == 0);
      exp_commit = (phase == 2) && (k != ebreak_at) && (pl[k][1:0] == 2'b00);
      chk("req_valid", imem_req_valid, exp_req);
      if (exp_req) chk("imem_addr", imem_addr, a);
      chk("commit", commit, exp_commit);
      chk("halted_run", halted, 0);
      chk("instret_run", instret, ir);
      if (phase == 2) begin
        chk("exec_pc", pc, a);
        chk("exec_cmd", cmd, wd[k]);
      end
      case (phase)
        0: if (imem_req_ready) begin
             phase = 1;
             dly   = $urandom_range(max_dly);
           end
        1: if (rsp_now) phase = 2;
           else dly--;
        default: begin
          if (k == ebreak_at) begin
            hlt = 1; done = 1;
          end else if (pl[k][1:0] != 2'b00) begin
            hlt = 1; err = 1; done = 1;
          end else begin
            ir++;
            a = pl[k];
            k++;
            phase = 0;
            if (k == n) done = 1;
          end
        end
      endcase
      if (stall > 0) stall--;
    end
    chk("prog_complete", done, 1);

    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("end_halted",    halted,    hlt);
    chk("end_fetch_err", fetch_err, err);
    chk("end_instret",   instret,   ir);
    chk("end_pc",        pc,        a);
    if (!hlt) begin
      chk("end_req_valid", imem_req_valid, 1);
      chk("end_addr",      imem_addr,      a);
    end else begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        imem_req_ready = $urandom_range(1);
        imem_rsp_valid = $urandom_range(1);
        imem_rsp_data  = $urandom();
        next_pc        = $urandom();
        #1;
        chk("halt_req_valid", imem_req_valid, 0);
        chk("halt_commit",    commit,         0);
        chk("halt_pc",        pc,             a);
        chk("halt_cmd",       cmd,            wd[k]);
        chk("halt_sticky",    halted,         1);
      end
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    int eb;
    int ma;
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    next_pc        = RPC;

    run_prog(3, -1, -1, 100, 0, 0, 0);   // sequential fetch
    run_prog(2, -1, -1, 100, 0, 5, 0);   // backpressure on first request
    run_prog(3, -1, -1, 100, 1, 0, 2);   // branch to 0x80000100
    run_prog(3, 2, -1, 100, 0, 0, 0);    // ebreak
    run_prog(1, -1, 0, 100, 0, 0, 0);    // misaligned next_pc 0x80000002

    for (int t = 0; t < 20; t++) begin
      n  = $urandom_range(12, 1);
      eb = ($urandom_range(3) == 0) ? int'($urandom_range(n - 1)) : -1;
      ma = ($urandom_range(3) == 0) ? int'($urandom_range(n - 1)) : -1;
      run_prog(n, eb, ma, $urandom_range(100, 30), $urandom_range(4), $urandom_range(3), 1);
    end

    // Asynchronous reset pulse in the middle of WAIT.
    run_prog(2, -1, -1, 100, 0, 0, 2);
    @(negedge clk);
    imem_req_ready = 1'b1;
    #1;
    chk("pre_rst_req", imem_req_valid, 1);
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midwait_rst_pc",      pc,             RPC);
    chk("midwait_rst_cmd",     cmd,            INSN_NOP);
    chk("midwait_rst_instret", instret,        0);
    chk("midwait_rst_req",     imem_req_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("restart_req_low", imem_req_valid, 0);
    @(negedge clk);
    #1;
    chk("restart_req",  imem_req_valid, 1);
    chk("restart_addr", imem_addr,      RPC);

`ifdef FETCH_WDOG_EN
    // No response: timeout after WDOG WAIT cycles.
    do_reset();
    @(negedge clk);
    imem_req_ready = 1'b1;
    #1;
    chk("wdog_req", imem_req_valid, 1);
    for (int i = 0; i < WDOG; i++) begin
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      #1;
      chk("wdog_wait_halted", halted, 0);
      chk("wdog_wait_req",    imem_req_valid, 0);
    end
    @(negedge clk);
    #1;
    chk("wdog_halted",    halted,    1);
    chk("wdog_fetch_err", fetch_err, 1);
    chk("wdog_pc",        pc,        RPC);

    // Response in the final permitted cycle is accepted.
    do_reset();
    @(negedge clk);
    imem_req_ready = 1'b1;
    for (int i = 0; i < WDOG; i++) begin
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_rsp_valid = (i == WDOG - 1);
      imem_rsp_data  = 32'h0050_0093;
      next_pc        = RPC + 32'd4;
    end
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #1;
    chk("wdog_late_commit", commit,    1);
    chk("wdog_late_cmd",    cmd,       32'h0050_0093);
    chk("wdog_late_err",    fetch_err, 0);
    @(negedge clk);
    #1;
    chk("wdog_late_halted", halted, 0);
    chk("wdog_late_pc",     pc,     RPC + 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
